// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    LOAD    = 2'd2
  } fetch_state_t;

  localparam int DEF_WIDTH      = 11;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_RESET_ADDR = 0;
  localparam int DEF_TIMEOUT    = 15;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register; a load of the target beats a sequential increment.
// Single-cycle update, no backpressure (caller qualifies load/inc).
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(DEF_RESET_ADDR)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  inc,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] pc
);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  // Increment wraps naturally at the address width.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target;
    end else if (inc) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: holds PC, requests instruction memory, strobes the captured word to the IR.
// One word per 2 cycles at zero wait; mem_rd held until mem_ready; stall/fetch_en gate new requests.
// FETCH_TIMEOUT_EN: abort a request after TIMEOUT wait cycles with a sticky fetch_error.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    WIDTH      = DEF_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(DEF_RESET_ADDR),
  parameter int                    TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fetch_en,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic [WIDTH-1:0]      mem_data,
  output logic [WIDTH-1:0]      fetch_instr,
  output logic                  fetch_ir_wr,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  fetch_busy,
  output logic                  fetch_error
);

  fetch_state_t          state_q, state_d;
  logic [WIDTH-1:0]      instr_q, instr_d;
  logic                  pc_load, pc_inc;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  start_ok;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // A latched error blocks any further fetch until reset.
  assign start_ok = fetch_en && !stall && !err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign start_ok       = fetch_en && !stall;
`endif

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    // Counter is held at zero outside REQUEST, so every request starts fresh.
    cnt_d = (state_q == REQUEST) ? cnt_q : '0;
    err_d = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (branch_taken) begin
          pc_load = 1'b1;
        end else if (start_ok) begin
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        if (mem_ready) begin
          instr_d = mem_data;
          state_d = LOAD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      LOAD: begin
        pc_load = branch_taken;
        pc_inc  = !branch_taken;
        state_d = start_ok ? REQUEST : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      instr_q <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  fetch_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_ADDR (RESET_ADDR)
  ) u_pc (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (pc_load),
    .inc     (pc_inc),
    .target  (branch_addr),
    .pc      (pc)
  );

  assign mem_rd      = (state_q == REQUEST);
  assign mem_addr    = pc;
  assign pc_out      = pc;
  assign fetch_ir_wr = (state_q == LOAD);
  assign fetch_busy  = (state_q != IDLE);
  assign fetch_instr = instr_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_error = err_q;
`else
  assign fetch_error = 1'b0;
`endif

endmodule
